// File: rtl/tx_header_hec_bluetooth_ble.sv
// tx_header_hec_bluetooth_ble
// Serialises a BLE/BR packet header and appends its 8-bit HEC.
// The header bits are delayed by one cycle. The HEC LFSR is seeded from uap_dci
// on the frame-start cycle and updated with every accepted header bit.
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-low reset
//   valid_in      header bit qualifier (held high for the whole header)
//   data_bit      serial header bit
//   uap_dci       LFSR seed, sampled on the frame-start cycle
//   n_bits        header length, sampled on the frame-start cycle
//   data_out      serial header bits followed by the HEC, MSB first
//   valid_out     data_out qualifier
//   busy          high while a frame is in flight
//   done          one-cycle pulse with the last HEC bit
//   err           one-cycle pulse on a frame error
//   hec_out       last computed HEC (only when TX_HEC_STATUS_EN is defined)
module tx_header_hec_bluetooth_ble #(
   parameter int unsigned HEC_LEN = 8,
   parameter int unsigned CNT_W   = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             data_bit,
   input  logic [7:0]       uap_dci,
   input  logic [CNT_W-1:0] n_bits,
   output logic             data_out,
   output logic             valid_out,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef TX_HEC_STATUS_EN
   ,
   output logic [7:0]       hec_out
`endif
);

   localparam int unsigned HC_W = $clog2(HEC_LEN);
   localparam logic [7:0]  POLY = 8'hA7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      HEC  = 2'd2
   } state_t;

   state_t            state;
   logic [7:0]        lfsr;
   logic [CNT_W-1:0]  bitcnt;
   logic [CNT_W-1:0]  n_reg;
   logic [HC_W-1:0]   hec_cnt;
   logic              hec_err_seen;
   logic [7:0]        lfsr_next_c;
   logic              hec_entry_c;

   // One LFSR step for D^8+D^7+D^5+D^2+D+1.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic b);
      logic fb;
      fb = b ^ s[7];
      return {s[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
   endfunction

   // The frame-start cycle steps from the fresh seed, not from the stale LFSR.
   always_comb begin
      lfsr_next_c = lfsr_step((state == IDLE) ? uap_dci : lfsr, data_bit);
      hec_entry_c = 1'b0;
      if (valid_in) begin
         if (state == IDLE) begin
            hec_entry_c = (n_bits == CNT_W'(1));
         end else if (state == DATA) begin
            hec_entry_c = ((bitcnt + CNT_W'(1)) == n_reg);
         end
      end
   end

   // Frame sequencer with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         lfsr         <= '0;
         bitcnt       <= '0;
         n_reg        <= '0;
         hec_cnt      <= '0;
         hec_err_seen <= 1'b0;
         data_out     <= 1'b0;
         valid_out    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         data_out  <= 1'b0;
         valid_out <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  if (n_bits == '0) begin
                     err <= 1'b1;
                  end else begin
                     lfsr         <= lfsr_next_c;
                     data_out     <= data_bit;
                     valid_out    <= 1'b1;
                     bitcnt       <= CNT_W'(1);
                     n_reg        <= n_bits;
                     hec_cnt      <= '0;
                     hec_err_seen <= 1'b0;
                     busy         <= 1'b1;
                     state        <= hec_entry_c ? HEC : DATA;
                  end
               end
            end
            DATA: begin
               if (valid_in) begin
                  lfsr      <= lfsr_next_c;
                  data_out  <= data_bit;
                  valid_out <= 1'b1;
                  bitcnt    <= bitcnt + CNT_W'(1);
                  if (hec_entry_c) begin
                     state <= HEC;
                  end
               end else begin
                  // Header cut short: drop the frame without any HEC.
                  err    <= 1'b1;
                  lfsr   <= '0;
                  bitcnt <= '0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            HEC: begin
               data_out  <= lfsr[7];
               valid_out <= 1'b1;
               lfsr      <= {lfsr[6:0], 1'b0};
               hec_cnt   <= hec_cnt + HC_W'(1);
               if (valid_in && !hec_err_seen) begin
                  err          <= 1'b1;
                  hec_err_seen <= 1'b1;
               end
               if (hec_cnt == HC_W'(HEC_LEN - 1)) begin
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  bitcnt <= '0;
                  state  <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef TX_HEC_STATUS_EN
   // Capture the complete HEC as the header's last bit is absorbed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hec_out <= '0;
      end else if (hec_entry_c) begin
         hec_out <= lfsr_next_c;
      end
   end
`endif

endmodule

// File: doc/tx_header_hec_bluetooth_ble.md
TX_HEADER_HEC_BLUETOOTH_BLE -- requirements
Module: tx_header_hec_bluetooth_ble

Interface
REQ-001 Parameter: HEC_LEN, default 8, number of HEC bits appended; only the value 8 is supported.
REQ-002 Parameter: CNT_W, default 14, width of the header bit counter and of n_bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  header bit qualifier; held high contiguously for the whole header.
REQ-006 data_bit  input  1  serial header bit, sampled when valid_in=1.
REQ-007 uap_dci  input  8  LFSR seed, sampled on the frame-start cycle only.
REQ-008 n_bits  input  CNT_W  header length in bits, sampled on the frame-start cycle only.
REQ-009 data_out  output  1  serial header bits, then HEC bits.
REQ-010 valid_out  output  1  data_out qualifier.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse, coincident with the last HEC bit.
REQ-013 err  output  1  one-cycle pulse on a frame error.

Function
REQ-014 The FSM SHALL have states IDLE, DATA and HEC.
REQ-015 The frame-start cycle is IDLE with valid_in=1; on it the LFSR SHALL load uap_dci, then process data_bit, with bitcnt=1.
- Next state: DATA, or HEC when n_bits=1.
REQ-016 Per accepted bit, the LFSR SHALL update as follows.
- fb = data_bit ^ lfsr[7].
- lfsr <= {lfsr[6:0],1'b0} ^ (fb ? 8'hA7 : 8'h00).
- Polynomial: D^8+D^7+D^5+D^2+D+1.
REQ-017 Latency SHALL be 1 cycle.
- Header bit k (k=0..N-1), accepted at cycle k, appears on data_out with valid_out=1 at cycle k+1.
REQ-018 DATA SHALL accept a bit each cycle with valid_in=1 and increment bitcnt; on accepting bit number N it SHALL enter HEC.
REQ-019 HEC SHALL emit lfsr[7] for 8 cycles, MSB first, shifting lfsr left with zero fill; these bits occupy cycles N+1..N+8.
REQ-020 done SHALL pulse with the 8th HEC bit, and the FSM SHALL then return to IDLE.
REQ-021 valid_in=1 during HEC SHALL be ignored and the bits discarded; err SHALL pulse once on the first such cycle.
REQ-022 valid_in=0 in DATA with bitcnt<N is a frame error, with the following response:
- err pulses.
- valid_out=0 from the next cycle.
- No HEC is emitted.
- The LFSR clears and the FSM returns to IDLE.
REQ-023 Frame start with n_bits=0 SHALL pulse err, emit nothing and remain in IDLE.
REQ-024 A new frame MAY start in the IDLE cycle immediately after done; the minimum inter-frame gap is 1 cycle.
REQ-025 When valid_out=0, data_out SHALL be 0.

Reset
REQ-026 On reset low, the following SHALL clear immediately, independent of clk:
- state=IDLE.
- lfsr=0, bitcnt=0.
- data_out=0, valid_out=0, busy=0, done=0, err=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; no partial HEC and no done SHALL follow release.
REQ-028 After reset release, the first frame SHALL be accepted on the first clk edge with valid_in=1.

Configuration
REQ-029 Macro TX_HEC_STATUS_EN SHALL control a status port.
- Defined: output hec_out[7:0] is added; it latches the full 8-bit HEC on entry to HEC, holds until the next frame's HEC entry, and resets to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Verification
REQ-030 Seed check: uap_dci=0x00, n_bits=1, bit=1.
- data_out = 1 then 1,0,1,0,0,1,1,1 (HEC 0xA7).
- done at cycle 9.
REQ-031 Zero frame: uap_dci=0x00, n_bits=10, all-zero bits.
- 10 zeros, then HEC 0x00.
- valid_out high cycles 1..18; done at cycle 18.
REQ-032 Abort: n_bits=10, valid_in drops after 6 bits.
- err pulses once; exactly 6 valid_out bits; no done; busy=0 after.
REQ-033 Back-to-back: two 10-bit frames, the second starting the cycle after done.
- Both frames emit 18 bits with correct HEC; the seed is re-sampled per frame.
REQ-034 Illegal input: valid_in held high through HEC gives 8 HEC bits unchanged and a single err; n_bits=0 gives err with no valid_out.
REQ-035 Reset mid-HEC: reset low at cycle N+4, then released.
- All outputs 0 immediately; no done afterwards; the next frame is correct.
